// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and default latencies for the HI/LO mul/div unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } muldiv_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at start into hold
// registers and committed after a fixed busy window; MTHI/MTLO write HI/LO immediately.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    muldiv_state_e state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [31:0]   hold_hi, hold_hi_n, hold_lo, hold_lo_n;
    logic          hold_wr, hold_wr_n;
    logic          busy_n;
    logic [31:0]   hi_n, lo_n;
    logic          is_muldiv;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a, mag_b, q_mag, r_mag, q_s, r_s, q_u, r_u, div_b;

    assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign stall_req = busy | (start & is_muldiv);

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 deterministically.
    // A zero divisor is replaced by 1 only to keep the arithmetic defined; no commit follows.
    assign div_b = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign mag_a = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign mag_b = div_b[31] ? (32'd0 - div_b) : div_b;
    assign q_mag = mag_a / mag_b;
    assign r_mag = mag_a % mag_b;
    assign q_s   = (rs_val[31] ^ div_b[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = rs_val[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = rs_val / div_b;
    assign r_u   = rs_val % div_b;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hold_hi_n = hold_hi;
        hold_lo_n = hold_lo;
        hold_wr_n = hold_wr;
        busy_n    = busy;
        hi_n      = HI;
        lo_n      = LO;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {hold_hi_n, hold_lo_n} = (op == OP_MULT) ? prod_s : prod_u;
                            hold_wr_n = 1'b1;
                            cnt_n     = 4'(MULT_CYCLES - 1);
                            busy_n    = 1'b1;
                            state_n   = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hold_hi_n = (op == OP_DIV) ? r_s : r_u;
                            hold_lo_n = (op == OP_DIV) ? q_s : q_u;
                            hold_wr_n = (rt_val != 32'd0);
                            cnt_n     = 4'(DIV_CYCLES - 1);
                            busy_n    = 1'b1;
                            state_n   = ST_RUN;
                        end
                        OP_MTHI: hi_n = rs_val;
                        OP_MTLO: lo_n = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt == 4'd0) begin
                    if (hold_wr) begin
                        hi_n = hold_hi;
                        lo_n = hold_lo;
                    end
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            hold_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            hold_wr <= hold_wr_n;
            HI      <= hi_n;
            LO      <= lo_n;
        end
    end

    // Hold registers carry data only; the FSM decides whether they ever reach HI/LO.
    always_ff @(posedge clk) begin
        hold_hi <= hold_hi_n;
        hold_lo <= hold_lo_n;
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed ops push expected HI/LO and busy length,
// a negedge monitor compares whenever busy falls.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_req;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    hilo_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall_req(stall_req),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge; stall_req is checked combinationally beforehand.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        #1;
        chk({name, "_stall_req"}, 32'(stall_req),
            32'((o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU)));
        tick();
        start = 1'b0;
        op    = OP_NOP;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n,
                        input string name);
        exp_t e;
        e.hi = h; e.lo = l; e.cycles = n; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            if (!busy) break;
            tick();
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: busy still 1 after 40 cycles, expected 0", name);
        end
        tick();
    endtask

    // Monitor: measure busy length and compare HI/LO when busy falls.
    int   busy_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            busy_len  = 0;
            prev_busy = 1'b0;
        end else begin
            if (start && busy) begin
                failures++;
                $display("FAIL protocol: start=1 while busy=1, expected start only when idle");
            end
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit: HI=0x%08h LO=0x%08h, expected no op in flight",
                             HI, LO);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_HI"}, HI, e.hi);
                    chk({e.name, "_LO"}, LO, e.lo);
                    chk({e.name, "_busy_cycles"}, 32'(busy_len), 32'(e.cycles));
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_NOP; rs_val = '0; rt_val = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("reset_HI", HI, 32'h0);
        chk("reset_LO", LO, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        issue(OP_MTHI, 32'h1234, 32'h0, "mthi");
        chk("mthi_HI", HI, 32'h1234);
        chk("mthi_busy", 32'(busy), 32'h0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst2_HI", HI, 32'h0);
        chk("rst2_LO", LO, 32'h0);
        chk("rst2_busy", 32'(busy), 32'h0);

        push(32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult_neg1x2");
        issue(OP_MULT, 32'hFFFFFFFF, 32'h2, "mult_neg1x2");
        chk("mult_busy_after_start", 32'(busy), 32'h1);
        wait_idle("mult_neg1x2");

        push(32'h00000001, 32'hFFFFFFFE, 5, "multu_max_x2");
        issue(OP_MULTU, 32'hFFFFFFFF, 32'h2, "multu_max_x2");
        wait_idle("multu_max_x2");

        push(32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult_neg3x5");
        issue(OP_MULT, 32'hFFFFFFFD, 32'h5, "mult_neg3x5");
        wait_idle("mult_neg3x5");

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg7_2");
        issue(OP_DIV, 32'hFFFFFFF9, 32'h2, "div_neg7_2");
        wait_idle("div_neg7_2");

        push(32'h1, 32'h3, 10, "divu_7_2");
        issue(OP_DIVU, 32'h7, 32'h2, "divu_7_2");
        wait_idle("divu_7_2");

        issue(OP_MTLO, 32'hAA, 32'h0, "mtlo");
        chk("mtlo_LO", LO, 32'hAA);
        issue(OP_MTHI, 32'hBB, 32'h0, "mthi_bb");
        chk("mthi_bb_HI", HI, 32'hBB);
        push(32'hBB, 32'hAA, 10, "div_by_zero");
        issue(OP_DIV, 32'h55, 32'h0, "div_by_zero");
        wait_idle("div_by_zero");

        push(32'h0, 32'h80000000, 10, "div_overflow");
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
        wait_idle("div_overflow");

        push(32'h0, 32'hF, 5, "mult_operand_toggle");
        issue(OP_MULT, 32'h3, 32'h5, "mult_operand_toggle");
        for (int i = 0; i < 4; i++) begin
            rs_val = $urandom;
            rt_val = $urandom;
            tick();
        end
        wait_idle("mult_operand_toggle");

        issue(OP_MULT, 32'h6, 32'h7, "mult_abort");
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_HI", HI, 32'h0);
        chk("abort_LO", LO, 32'h0);
        repeat (8) tick();
        chk("abort_late_HI", HI, 32'h0);
        chk("abort_late_LO", LO, 32'h0);
        chk("abort_late_busy", 32'(busy), 32'h0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
